// File: rtl/phase_scheduler.sv
// rtl/phase_scheduler.sv - round-robin green-phase sequencer with pedestrian walk and emergency preemption
// Optional PHASE_SKIP_EN: only approaches with a latched request are eligible for a green phase.
module phase_scheduler #(
  parameter int TG_W      = 8,
  parameter int MIN_GREEN = 5,
  parameter int PED_TIME  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic            ped_button,
  input  logic            em_button,
  input  logic [1:0]      em_dir,
  input  logic [TG_W-1:0] TG0,
  input  logic [TG_W-1:0] TG1,
  input  logic [TG_W-1:0] TG2,
  input  logic [TG_W-1:0] TG3,
  input  logic            phase_done,
  output logic [3:0]      grant,
  output logic [TG_W-1:0] green_time,
  output logic            start,
  output logic            abort,
  output logic            ped_walk,
  output logic [2:0]      state
);

  localparam int CNT_W = $clog2(PED_TIME + 1);
  localparam logic [TG_W-1:0]  MIN_G    = TG_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PED_TIME - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    PED   = 3'd3,
    EMERG = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [TG_W-1:0]  green_q, green_d;
  logic             start_q, start_d;
  logic             abort_q, abort_d;
  logic             walk_q, walk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       pend_q, pend_d;
  logic             ped_pend_q, ped_pend_d;

  logic [3:0]       pend_clr;
  logic             ped_clr;
  logic [1:0]       pick;
  logic             any_elig;
  logic [TG_W-1:0]  tg_pick;

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

`ifdef PHASE_SKIP_EN
  // Scan downward so the last hit is the first pending approach at or after ptr.
  always_comb begin
    logic [1:0] cand;
    cand     = ptr_q;
    pick     = ptr_q;
    any_elig = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (pend_q[cand]) begin
        pick     = cand;
        any_elig = 1'b1;
      end
    end
  end
`else
  assign pick     = ptr_q;
  assign any_elig = 1'b1;
`endif

  always_comb begin
    case (pick)
      2'd0:    tg_pick = TG0;
      2'd1:    tg_pick = TG1;
      2'd2:    tg_pick = TG2;
      default: tg_pick = TG3;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    green_d  = green_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    walk_d   = 1'b0;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    pend_clr = 4'b0000;
    ped_clr  = 1'b0;

    if (em_button) begin
      state_d = EMERG;
      grant_d = onehot(em_dir);
      abort_d = (state_q == WAIT);
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          grant_d = 4'b0000;
          cnt_d   = '0;
          if (ped_pend_q) begin
            state_d = PED;
            walk_d  = 1'b1;
            ped_clr = 1'b1;
          end else if (any_elig) begin
            state_d = ISSUE;
            grant_d = onehot(pick);
            start_d = 1'b1;
            green_d = (tg_pick < MIN_G) ? MIN_G : tg_pick;
            ptr_d   = pick + 2'd1;
          end
        end
        ISSUE: begin
          state_d  = WAIT;
          pend_clr = grant_q;
        end
        WAIT: begin
          if (phase_done) begin
            grant_d = 4'b0000;
            cnt_d   = '0;
            if (ped_pend_q) begin
              state_d = PED;
              walk_d  = 1'b1;
              ped_clr = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        PED: begin
          grant_d = 4'b0000;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            walk_d = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end
        EMERG: begin
          // Resume rotation just past the approach the emergency vehicle used.
          state_d  = IDLE;
          grant_d  = 4'b0000;
          ptr_d    = em_dir + 2'd1;
          pend_clr = onehot(em_dir);
        end
        default: begin
          state_d = IDLE;
          grant_d = 4'b0000;
        end
      endcase
    end
  end

  // A new request in the clearing cycle wins so it is never lost.
  assign pend_d     = (pend_q & ~pend_clr) | req;
  assign ped_pend_d = (ped_pend_q & ~ped_clr) | ped_button;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 4'b0000;
      green_q    <= '0;
      start_q    <= 1'b0;
      abort_q    <= 1'b0;
      walk_q     <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= 2'd0;
      pend_q     <= 4'b0000;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      green_q    <= green_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      walk_q     <= walk_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  assign grant      = grant_q;
  assign green_time = green_q;
  assign start      = start_q;
  assign abort      = abort_q;
  assign ped_walk   = walk_q;
  assign state      = state_q;

endmodule

// File: tb/tb_phase_scheduler.sv
// tb/tb_phase_scheduler.sv - scoreboard bench for phase_scheduler (fixed rotation, or skip mode when PHASE_SKIP_EN)
module tb_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       ped_button = 1'b0;
  logic       em_button = 1'b0;
  logic [1:0] em_dir = 2'd0;
  logic [7:0] TG0 = 8'd8;
  logic [7:0] TG1 = 8'd12;
  logic [7:0] TG2 = 8'd3;
  logic [7:0] TG3 = 8'd20;
  logic       phase_done = 1'b0;
  logic [3:0] grant;
  logic [7:0] green_time;
  logic       start;
  logic       abort;
  logic       ped_walk;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] issue_q[$];
  logic [3:0]  abort_q[$];
  int          walk_q[$];

  phase_scheduler #(.TG_W(8), .MIN_GREEN(5), .PED_TIME(10)) dut (
    .clk(clk), .reset(reset), .req(req), .ped_button(ped_button),
    .em_button(em_button), .em_dir(em_dir),
    .TG0(TG0), .TG1(TG1), .TG2(TG2), .TG3(TG3),
    .phase_done(phase_done), .grant(grant), .green_time(green_time),
    .start(start), .abort(abort), .ped_walk(ped_walk), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start();
    int k;
    k = 0;
    while (start !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    if (start !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL start_timeout: got no start expected start within 40 cycles");
    end
  endtask

  task automatic phase_end();
    tick();
    tick();
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_grant", grant, 0);
    check("rst_green_time", green_time, 0);
    check("rst_start", start, 0);
    check("rst_abort", abort, 0);
    check("rst_ped_walk", ped_walk, 0);
    check("rst_state", state, 0);
  endtask

  // Monitor: checks every start/abort/walk interval against the scoreboard queues.
  logic [3:0] prev_grant = 4'b0000;
  int         walk_cnt = 0;
  always @(negedge clk) begin
    logic [11:0] e;
    logic [3:0]  a;
    int          w;
    if (start === 1'b1) begin
      if (issue_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_start: got grant %0d expected no issue", grant);
      end else begin
        e = issue_q.pop_front();
        check("issue_grant", grant, e[11:8]);
        check("issue_green_time", green_time, e[7:0]);
        check("all_red_before_issue", prev_grant, 0);
      end
    end
    if (abort === 1'b1) begin
      if (abort_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_abort: got abort expected none");
      end else begin
        a = abort_q.pop_front();
        check("abort_grant", grant, a);
      end
    end
    if (ped_walk === 1'b1) begin
      walk_cnt++;
      check("walk_all_red", grant, 0);
    end else if (walk_cnt != 0) begin
      if (walk_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_walk: got %0d cycles expected none", walk_cnt);
      end else begin
        w = walk_q.pop_front();
        check("walk_length", walk_cnt, w);
      end
      walk_cnt = 0;
    end
    prev_grant = grant;
  end

  initial begin
    tick();
    tick();
    check_reset_outputs();

`ifdef PHASE_SKIP_EN
    reset = 1'b0;
    tick();
    tick();
    check("skip_idle_no_req", state, 0);
    issue_q.push_back({4'd2, 8'd12});
    issue_q.push_back({4'd8, 8'd20});
    issue_q.push_back({4'd1, 8'd8});
    req = 4'b1010;
    tick();
    req = 4'b0000;
    wait_start();
    tick();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    wait_start();
    phase_end();
    wait_start();
    phase_end();
    repeat (10) tick();
    check("skip_idle_state", state, 0);
    check("skip_idle_grant", grant, 0);
`else
    // Fixed rotation N,E,S,W,N with TG2 raised to the minimum.
    issue_q.push_back({4'd1, 8'd8});
    issue_q.push_back({4'd2, 8'd12});
    issue_q.push_back({4'd4, 8'd5});
    issue_q.push_back({4'd8, 8'd20});
    issue_q.push_back({4'd1, 8'd8});
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_start();
      if (i < 4) phase_end();
    end

    // Pedestrian press during E: walk of 10, rotation resumes at S.
    issue_q.push_back({4'd2, 8'd12});
    phase_end();
    wait_start();
    tick();
    ped_button = 1'b1;
    tick();
    ped_button = 1'b0;
    walk_q.push_back(10);
    issue_q.push_back({4'd4, 8'd5});
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    wait_start();

    issue_q.push_back({4'd8, 8'd20});
    phase_end();
    wait_start();
    issue_q.push_back({4'd1, 8'd8});
    phase_end();
    wait_start();

    // Emergency towards S while N is timing: abort, then W is next.
    tick();
    em_dir = 2'd2;
    em_button = 1'b1;
    abort_q.push_back(4'd4);
    tick();
    check("emerg_grant", grant, 4);
    check("emerg_state", state, 4);
    repeat (6) tick();
    check("emerg_hold_grant", grant, 4);
    em_button = 1'b0;
    tick();
    check("emerg_exit_state", state, 0);
    check("emerg_exit_grant", grant, 0);
    issue_q.push_back({4'd8, 8'd20});
    wait_start();

    // Emergency and phase_done together: straight to EMERG with abort.
    tick();
    em_dir = 2'd1;
    em_button = 1'b1;
    phase_done = 1'b1;
    abort_q.push_back(4'd2);
    tick();
    phase_done = 1'b0;
    check("em_done_state", state, 4);
    tick();
    em_button = 1'b0;
    issue_q.push_back({4'd4, 8'd5});
    tick();
    wait_start();

    // Reset during the walk interval, then rotation restarts at N.
    tick();
    ped_button = 1'b1;
    tick();
    ped_button = 1'b0;
    walk_q.push_back(3);
    phase_done = 1'b1;
    tick();
    phase_done = 1'b0;
    check("ped_entry_state", state, 3);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_reset_outputs();
    issue_q.push_back({4'd1, 8'd8});
    reset = 1'b0;
    wait_start();
`endif

    repeat (4) tick();
    check("issue_queue_drained", issue_q.size(), 0);
    check("abort_queue_drained", abort_q.size(), 0);
    check("walk_queue_drained", walk_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/phase_scheduler.md
# phase_scheduler

Sequencing controller for the four-approach intersection: decides which approach (N=0, E=1, S=2, W=3) gets the next green phase and hands the phase to the countdown timer through a start/done handshake. It latches per-approach vehicle requests, the pedestrian button and emergency preemption. It clamps each approach's green time, then issues one phase at a time in round-robin order. It sits between the button and sensor inputs and the phase timer, upstream of the seven-segment display path.

## Interface
- `TG_W`, 8, width of the green-time operands.
- `MIN_GREEN`, 5, minimum issued green time; smaller TG values are raised to this.
- `PED_TIME`, 10, all-red walk interval, in clock cycles.
- `clk` input 1, rising-edge clock.
- `reset` input 1, synchronous, active-high.
- `req` input 4, vehicle-present level per approach, bit i = approach i.
- `ped_button` input 1, pedestrian request; level-sampled and latched.
- `em_button` input 1, emergency preemption, active while high.
- `em_dir` input 2, approach to serve during emergency; sampled while `em_button` is high.
- `TG0`..`TG3` input TG_W, green time per approach.
- `phase_done` input 1, one-cycle pulse from the timer when the issued green expires.
- `grant` output 4, one-hot green approach; 0 = all red.
- `green_time` output TG_W, time for the granted phase; valid while `start` is high.
- `start` output 1, one-cycle pulse that launches the timer.
- `abort` output 1, one-cycle pulse that cancels the running timer on preemption.
- `ped_walk` output 1, high during the walk interval.
- `state` output 3, encoded FSM state.

## Operation
- State encoding: IDLE=0, ISSUE=1, WAIT=2, PED=3, EMERG=4.
- Request latch `pend[3:0]`:
  - A bit sets when `req[i]` is high.
  - The bit clears on the ISSUE cycle for approach i.
  - If set and clear occur in the same cycle, set wins.
- Pedestrian latch `ped_pend`:
  - Sets on `ped_button`.
  - Clears on entry to PED.
  - A press during PED is latched for the next walk.
- Round-robin pointer `ptr` (2 bits) holds the next approach to consider.
  - The next approach is the first eligible one starting at `ptr`, wrapping 3→0.
- IDLE:
  - If `ped_pend` is set, go to PED.
  - Otherwise, if an approach is eligible, go to ISSUE.
  - Otherwise stay in IDLE with `grant`=0.
- ISSUE (one cycle):
  - Drive `grant` to the one-hot of the selected approach and pulse `start`.
  - `green_time` = max(TGi, MIN_GREEN), unsigned compare.
  - Set `ptr` = selected approach + 1 (mod 4).
  - Go to WAIT.
- WAIT:
  - Hold `grant`.
  - On `phase_done`, go to PED if `ped_pend` is set, else go to IDLE.
  - `phase_done` is ignored in the ISSUE cycle.
- PED:
  - `grant`=0 and `ped_walk`=1 for exactly PED_TIME cycles, counted by an internal counter of width $clog2(PED_TIME+1).
  - Then go to IDLE.
- EMERG (entered from any state when `em_button`=1):
  - On entry from WAIT, pulse `abort` in the first EMERG cycle.
  - `grant` follows one-hot(`em_dir`) every cycle.
  - `ped_walk` drops immediately; the PED counter resets and walk is not resumed.
  - On `em_button`=0, set `ptr` = `em_dir` + 1 and go to IDLE. `pend[em_dir]` is cleared on exit.
- Priority in any single cycle: `reset` > `em_button` > `phase_done` > `ped_pend` > vehicle requests.

## Timing
- Reset values:
  - Outputs: `grant`=0, `green_time`=0, `start`=0, `abort`=0, `ped_walk`=0, `state`=IDLE.
  - Internal state: `ptr`=0, `pend`=0, `ped_pend`=0, counter=0.
- Reset asserted mid-phase forces the values above on the next edge. No `abort` pulse is issued.
- Request to grant: `req` high in cycle n sets `pend` at edge n+1. With the FSM idle, IDLE→ISSUE occurs at n+2, and `grant`/`start` are visible from that edge.
- Phase end: `phase_done` in cycle n gives IDLE at n+1, and the next ISSUE no earlier than n+2.
  - Between phases there is at least one all-red cycle (`grant`=0).
- Emergency: `em_button` high in cycle n gives EMERG with the emergency grant from edge n+1. Exit occurs one cycle after `em_button` falls.
- `green_time` is registered with `start` and holds its value until the next ISSUE.

## Configuration
- `PHASE_SKIP_EN` defined:
  - Only approaches with `pend[i]`=1 are eligible.
  - Approaches without requests are skipped.
  - IDLE persists with all red while no requests are pending.
- `PHASE_SKIP_EN` undefined:
  - Every approach is eligible; the order is strict N→E→S→W regardless of `pend`.
  - IDLE always advances to PED or ISSUE on the next cycle.
  - `pend` is still maintained and cleared.

## Test plan
- Fixed rotation (macro off), TG0..3 = 8, 12, 3, 20, `phase_done` 2 cycles after each `start` → `grant` sequence 1, 2, 4, 8, 1 with `green_time` 8, 12, 5, 20.
- Skip mode (macro on): `req`=4'b1010 pulsed once → only E then W are granted, after which IDLE with `grant`=0. `req[0]` raised during the E phase → N is issued after W, wrap verified.
- `ped_button` during an E phase → after `phase_done`, `ped_walk` is high for exactly 10 cycles with `grant`=0, then rotation resumes at S.
- `em_button`=1, `em_dir`=2 during WAIT on N → next cycle `abort`=1 and `grant`=4. Hold 7 cycles, release → IDLE, next issue is W (macro off).
- `em_button` and `phase_done` in the same cycle → EMERG entered, no IDLE cycle, `abort`=1. `reset` asserted during PED → all outputs 0 at the next edge and `ptr`=0.
